// File: rtl/pipe_pkg.sv
// Shared types for the ID-stage hazard scoreboard: in-flight register tags,
// the interlock FSM state encoding and the hard-wired zero register.
package pipe_pkg;

    typedef struct packed {
        logic       v;
        logic [4:0] a;
    } reg_tag_t;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        STALL   = 2'd1,
        RECOVER = 2'd2
    } hz_state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam reg_tag_t   TAG_NONE = '{v: 1'b0, a: REG_ZERO};

endpackage

// File: rtl/id_hazard_scoreboard_tag_match.sv
// Compares one ID source address against the three in-flight destination
// tags. The WB tag only counts when the register file cannot bypass a WB
// write into a same-cycle ID read. Register 0 never hits.
module tag_match
    import pipe_pkg::*;
(
    input  reg_tag_t   tag_ex,
    input  reg_tag_t   tag_mem,
    input  reg_tag_t   tag_wb,
    input  logic       wb_en,
    input  logic [4:0] addr,
    output logic       hit
);

    logic hit_ex;
    logic hit_mem;
    logic hit_wb;

    // Per-stage address compare, qualified by tag valid.
    always_comb begin
        hit_ex  = tag_ex.v  && (tag_ex.a  == addr);
        hit_mem = tag_mem.v && (tag_mem.a == addr);
        hit_wb  = wb_en && tag_wb.v && (tag_wb.a == addr);
        hit     = (addr != REG_ZERO) && (hit_ex || hit_mem || hit_wb);
    end

endmodule

// File: rtl/id_hazard_scoreboard.sv
// ID-stage register-read interlock for the 5-stage pipeline (no forwarding).
// Holds a reader in ID until every in-flight producer of its sources has
// reached the register file, sequences flush recovery, and counts stall
// cycles for debug.
//
// state   | meaning
// --------+-------------------------------------------------------------
// RUN     | normal issue, no interlock pending
// STALL   | reader held in ID waiting for a producer to write back
// RECOVER | one cycle after a flush; wrong-path IF/ID content is bubbled
module id_hazard_scoreboard
    import pipe_pkg::*;
#(
    parameter int WB_BYPASS = 0,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_ID,
    input  logic             id_valid,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_rs_used,
    input  logic             id_rt_used,
    input  logic [4:0]       id_dst,
    input  logic             id_dst_we,
    input  logic             flush,
    output logic             pause_IF,
    output logic             bubble_EX,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic WB_EN = (WB_BYPASS == 0);

    reg_tag_t         tag_ex_q,  tag_ex_d;
    reg_tag_t         tag_mem_q, tag_mem_d;
    reg_tag_t         tag_wb_q,  tag_wb_d;
    hz_state_t        state_q,   state_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic rs_hit;
    logic rt_hit;
    logic hz;

    tag_match u_match_rs (
        .tag_ex  (tag_ex_q),
        .tag_mem (tag_mem_q),
        .tag_wb  (tag_wb_q),
        .wb_en   (WB_EN),
        .addr    (id_rs),
        .hit     (rs_hit)
    );

    tag_match u_match_rt (
        .tag_ex  (tag_ex_q),
        .tag_mem (tag_mem_q),
        .tag_wb  (tag_wb_q),
        .wb_en   (WB_EN),
        .addr    (id_rt),
        .hit     (rt_hit)
    );

    // Hazard detect and pipeline control; flush always wins over a stall.
    // Reset gating keeps both controls low while rst_ID is held, whatever
    // flush is doing.
    always_comb begin
        hz        = id_valid && ((id_rs_used && rs_hit) || (id_rt_used && rt_hit));
        pause_IF  = !rst_ID && hz && !flush;
        bubble_EX = !rst_ID && (hz || flush || (state_q == RECOVER));
        stall_cnt = stall_cnt_q;
    end

    // Next tag values: shift down the pipe, squash EX on flush, and only
    // tag an ID instruction that really issues and writes a nonzero register.
    always_comb begin
        tag_wb_d  = tag_mem_q;
        tag_mem_d = flush ? TAG_NONE : tag_ex_q;
        tag_ex_d  = TAG_NONE;
        if (id_valid && id_dst_we && (id_dst != REG_ZERO) && !bubble_EX) begin
            tag_ex_d = '{v: 1'b1, a: id_dst};
        end
    end

    // Interlock FSM next state; RECOVER lasts exactly one cycle unless
    // another flush arrives.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = RECOVER;
        end else begin
            case (state_q)
                RUN:     if (hz) state_d = STALL;
                STALL:   if (!hz) state_d = RUN;
                RECOVER: state_d = RUN;
                default: state_d = RUN;
            endcase
        end
    end

    // Saturating count of cycles in which fetch was paused.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (pause_IF && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst_ID) begin
        if (rst_ID) begin
            tag_ex_q    <= TAG_NONE;
            tag_mem_q   <= TAG_NONE;
            tag_wb_q    <= TAG_NONE;
            state_q     <= RUN;
            stall_cnt_q <= '0;
        end else begin
            tag_ex_q    <= tag_ex_d;
            tag_mem_q   <= tag_mem_d;
            tag_wb_q    <= tag_wb_d;
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule
